echo_locator: RTL
=================

ECHO_LOCATOR -- requirements
Module: echo_locator

Interface
REQ-001 The module SHALL have parameter NBITS, default 400, meaning the nominal frame length in bits.
REQ-002 The module SHALL have parameter MIN_WIDTH, default 2, meaning the minimum accepted echo width in bits (1..15).
REQ-003 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous assert, active-low.
REQ-005 Port data_en  input  1  is high for every valid serial bit of a frame; a frame is one contiguous high run.
REQ-006 Port serial_data  input  1  is the sample bit, LSB-first, qualified by data_en.
REQ-007 Port echo_pos  output  9  is the bit index of the accepted echo's first 1-bit.
REQ-008 Port echo_width  output  9  is the accepted echo's width in bits.
REQ-009 Port echo_valid  output  1  is a one-cycle pulse: the frame contained an accepted echo.
REQ-010 Port frame_done  output  1  is a one-cycle pulse marking the end of each frame.
REQ-011 Port frame_err  output  1  is valid with frame_done; high when frame length != NBITS.

Function
REQ-012 The block SHALL keep a 9-bit bit index idx, cleared at frame start, incremented per data_en cycle, saturating at 511.
REQ-013 The first data_en cycle of a frame SHALL be index 0; the previous-bit register SHALL read 0 at frame start, so a 1 at index 0 is a rising edge.
REQ-014 The FSM SHALL have states IDLE, SEARCH, PULSE, HOLD, REPORT.
REQ-015 IDLE -> SEARCH on data_en=1; that bit is processed in the same cycle (a 1 there enters PULSE directly).
REQ-016 In SEARCH, serial_data=1 SHALL latch start=idx, set width=1, go to PULSE.
REQ-017 In PULSE, each further 1 SHALL increment width (saturating at 511).
REQ-018 In PULSE, a 0 with width >= MIN_WIDTH SHALL record start/width and go to HOLD.
REQ-019 In PULSE, a 0 with width < MIN_WIDTH SHALL discard the run and go to SEARCH.
REQ-020 In HOLD, remaining bits SHALL be ignored; only the first accepted echo per frame is reported.
REQ-021 Bits with idx >= NBITS SHALL not start or extend an echo and SHALL set frame_err.
REQ-022 On data_en 1->0 in any state, the block SHALL go to REPORT; a run still in PULSE SHALL be accepted iff width >= MIN_WIDTH.
REQ-023 In REPORT (one cycle, the cycle after the first data_en=0 cycle), frame_done=1, echo_valid=1 iff an echo was recorded, then -> IDLE.
REQ-024 frame_err SHALL be 1 in REPORT iff the frame had fewer or more than NBITS data_en cycles.
REQ-025 echo_pos/echo_width SHALL update only in REPORT and hold until the next REPORT; with no echo they SHALL load 9'h1FF / 9'd0.
REQ-026 A data_en=1 during REPORT SHALL be processed as index 0 of a new frame while REPORT outputs complete.

Reset
REQ-027 With rst=0 all outputs SHALL be 0 except echo_pos=9'h1FF; the FSM SHALL be IDLE; idx, start, width SHALL be 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no frame_done; after release the block SHALL wait in IDLE for the next data_en rising edge, treating any data_en already high as a new frame at index 0.

Verification
REQ-029 400-bit frame, ones at idx 37..41 -> frame_done, echo_valid, echo_pos=37, echo_width=5, frame_err=0.
REQ-030 Frame with single 1 at idx 10, then ones 100..102 -> echo_pos=100, width=3 (glitch rejected).
REQ-031 All-zero 400-bit frame -> frame_done=1, echo_valid=0, echo_pos=9'h1FF, width=0.
REQ-032 Ones at idx 0..1 and 397..399 -> echo_pos=0, width=2; 398..399-only frame -> echo_pos=398, width=2 (end-of-frame acceptance).
REQ-033 Frame of 405 bits with ones 401..404 -> echo_valid=0, frame_err=1; 390-bit frame -> frame_err=1.
REQ-034 rst asserted at idx 200 of a frame -> no frame_done; next full frame reports correctly; back-to-back frames with one idle cycle each give one frame_done per frame.

Source files
------------

// File: rtl/echo_locator.sv
// Finds the first accepted run of 1-bits (width >= MIN_WIDTH) in each serial frame and reports it.
// Latency: results appear one cycle after data_en falls; no backpressure, the bit stream is never stalled.
module echo_locator #(
    parameter int NBITS     = 400,
    parameter int MIN_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_en,
    input  logic       serial_data,
    output logic [8:0] echo_pos,
    output logic [8:0] echo_width,
    output logic       echo_valid,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {IDLE, SEARCH, PULSE, HOLD, REPORT} state_t;

    localparam logic [9:0] NBITS_W = 10'(NBITS);
    localparam logic [8:0] MIN_W   = 9'(MIN_WIDTH);

    state_t     state;
    logic [8:0] idx;
    logic [8:0] start;
    logic [8:0] width;
    logic [8:0] rec_start;
    logic [8:0] rec_width;
    logic       rec_vld;
    logic       over;

    logic       frame_start;
    state_t     eff_state;
    logic [8:0] cur_idx;
    logic [8:0] idx_inc;
    logic [8:0] width_inc;
    logic       in_range;
    logic       bit_in;
    logic       run_ok;
    logic       fin_vld;
    logic [8:0] fin_start;
    logic [8:0] fin_width;

    // A data_en in IDLE or REPORT opens a new frame; that bit is handled as SEARCH at index 0.
    assign frame_start = data_en && (state == IDLE || state == REPORT);
    assign eff_state   = frame_start ? SEARCH : state;
    assign cur_idx     = frame_start ? 9'd0 : idx;
    assign idx_inc     = (cur_idx == 9'h1FF) ? cur_idx : cur_idx + 9'd1;
    assign width_inc   = (width == 9'h1FF) ? width : width + 9'd1;
    assign in_range    = {1'b0, cur_idx} < NBITS_W;
    assign bit_in      = serial_data && in_range;
    assign run_ok      = width >= MIN_W;

    // A run still open when the frame ends is accepted if wide enough.
    assign fin_vld   = rec_vld || (state == PULSE && run_ok);
    assign fin_start = rec_vld ? rec_start : start;
    assign fin_width = rec_vld ? rec_width : width;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 9'd0;
            start      <= 9'd0;
            width      <= 9'd0;
            rec_start  <= 9'd0;
            rec_width  <= 9'd0;
            rec_vld    <= 1'b0;
            over       <= 1'b0;
            echo_pos   <= 9'h1FF;
            echo_width <= 9'd0;
            echo_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            echo_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (data_en) begin
                idx  <= idx_inc;
                over <= (frame_start ? 1'b0 : over) | ~in_range;
                if (frame_start) begin
                    rec_vld <= 1'b0;
                end
                case (eff_state)
                    SEARCH: begin
                        if (bit_in) begin
                            start <= cur_idx;
                            width <= 9'd1;
                            state <= PULSE;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    PULSE: begin
                        // Bits past the nominal frame end close the run like a 0.
                        if (bit_in) begin
                            width <= width_inc;
                        end else if (run_ok) begin
                            rec_vld   <= 1'b1;
                            rec_start <= start;
                            rec_width <= width;
                            state     <= HOLD;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end else if (state == SEARCH || state == PULSE || state == HOLD) begin
                state      <= REPORT;
                frame_done <= 1'b1;
                frame_err  <= over || ({1'b0, idx} < NBITS_W);
                echo_valid <= fin_vld;
                echo_pos   <= fin_vld ? fin_start : 9'h1FF;
                echo_width <= fin_vld ? fin_width : 9'd0;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
